// File: rtl/sclk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sclk_ctrl_pkg
// Purpose  : Shared types and constants for the sclk run/stop and rate
//            controller: controller state encoding and the minimum legal
//            half-period.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sclk_ctrl_pkg;

  // Controller state: IDLE parks sclk low; RUN and STOP_PEND both count.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  // Smallest half-period; a requested 0 is raised to this value.
  localparam int MIN_HALF = 1;

endpackage : sclk_ctrl_pkg
`default_nettype wire

// File: rtl/sclk_half_counter.sv
`default_nettype none
// ============================================================================
// Module   : sclk_half_counter
// Purpose  : Half-period counter for the sclk divider. Counts clk cycles
//            while enabled and flags the last cycle of each half-period.
// Ports    : clk       in  1      system clock
//            reset     in  1      asynchronous, active-high reset
//            en        in  1      count enable; low holds the count at zero
//            half      in  CNT_W  half-period in force (always >= 1)
//            count     out CNT_W  cycles elapsed in the current half-period
//            boundary  out 1      last cycle of the half-period (en && count == half-1)
// Revision : 1.0 - initial release
// ============================================================================
module sclk_half_counter
  import sclk_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] half,
  output logic [CNT_W-1:0] count,
  output logic             boundary
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(MIN_HALF);

  // half never drops below 1, so half-1 cannot underflow, and half only
  // changes at a boundary or while disabled, so count < half always holds.
  assign boundary = en && (count == (half - ONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!en || boundary) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

endmodule : sclk_half_counter
`default_nettype wire

// File: rtl/sclk_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sclk_rate_ctrl
// Purpose  : Run/stop and rate controller for the slow serial clock sclk.
//            Owns the sclk toggle flop and accepts half-period updates over a
//            valid/ready handshake. While sclk is running, updates are held
//            in a pending register and only take effect on an sclk edge, so
//            sclk never glitches. sclk always parks low; a stop completes on
//            a falling edge and never truncates a high phase.
// Ports    : clk        in  1      system clock
//            reset      in  1      asynchronous, active-high reset
//            run        in  1      1 = generate sclk, 0 = stop at a falling edge
//            cfg_valid  in  1      new half-period offered
//            cfg_half   in  CNT_W  requested half-period (0 treated as 1)
//            cfg_ready  out 1      controller accepts cfg this cycle
//            sclk       out 1      divided clock (registered)
//            sclk_rise  out 1      pulse in the first cycle sclk reads 1
//            sclk_fall  out 1      pulse in the first cycle sclk reads 0
//            active     out 1      high in RUN or STOP_PEND
//            half_cur   out CNT_W  half-period currently in force
// Revision : 1.0 - initial release
// ============================================================================
module sclk_rate_ctrl
  import sclk_ctrl_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int unsigned DEFAULT_HALF = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             sclk,
  output logic             sclk_rise,
  output logic             sclk_fall,
  output logic             active,
  output logic [CNT_W-1:0] half_cur
);

  localparam logic [CNT_W-1:0] RESET_HALF = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] MIN_HALF_W = CNT_W'(MIN_HALF);

  state_t           state;
  state_t           next_state;
  logic             count_en;
  logic             boundary;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pending;
  logic             pending_vld;
  logic             cfg_take;
  logic [CNT_W-1:0] cfg_value;

  assign cfg_take  = cfg_valid && cfg_ready;
  assign cfg_value = (cfg_half < MIN_HALF_W) ? MIN_HALF_W : cfg_half;

  sclk_half_counter #(
    .CNT_W (CNT_W)
  ) u_half_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (count_en),
    .half     (half_cur),
    .count    (count),
    .boundary (boundary)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (run) next_state = RUN;
      end
      RUN: begin
        if (!run) next_state = STOP_PEND;
      end
      STOP_PEND: begin
        // A renewed run request wins over a falling boundary in the same
        // cycle, so resuming never produces a stop/restart hiccup.
        if (run) begin
          next_state = RUN;
        end else if (boundary && sclk) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    count_en = 1'b0;
    case (state)
      RUN, STOP_PEND: count_en = 1'b1;
      default:        count_en = 1'b0;
    endcase
    active = count_en;
  end

  // --------------------------------------------------------------------------
  // sclk flop, edge pulses, config handshake and pending register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk        <= 1'b0;
      sclk_rise   <= 1'b0;
      sclk_fall   <= 1'b0;
      cfg_ready   <= 1'b1;
      half_cur    <= RESET_HALF;
      pending     <= '0;
      pending_vld <= 1'b0;
    end else begin
      // boundary is only ever true while counting, so no pulses in IDLE
      // apart from the final fall that lands in the cycle IDLE is entered.
      sclk_rise <= boundary && !sclk;
      sclk_fall <= boundary && sclk;
      if (boundary) begin
        sclk <= ~sclk;
      end

      if (!count_en) begin
        // A value accepted in the very cycle the stop completed is still
        // sitting in pending; fold it in here so cfg_ready cannot stick low.
        if (pending_vld) begin
          half_cur    <= pending;
          pending_vld <= 1'b0;
          cfg_ready   <= 1'b1;
        end else if (cfg_take) begin
          half_cur <= cfg_value;
        end
      end else begin
        // cfg_ready is low whenever pending_vld is set, so a new transfer
        // and an apply can never collide in the same cycle.
        if (boundary && pending_vld) begin
          half_cur    <= pending;
          pending_vld <= 1'b0;
          cfg_ready   <= 1'b1;
        end else if (cfg_take) begin
          pending     <= cfg_value;
          pending_vld <= 1'b1;
          cfg_ready   <= 1'b0;
        end
      end
    end
  end

endmodule : sclk_rate_ctrl
`default_nettype wire
